apb3_crc_engine: RTL
====================

Name: apb3_crc_engine

Overview:
Parametrised APB3 slave wrapping a programmable CRC engine. Successor to the fixed 32-bit APB3 CRC slave. Generalises CRC width and bits processed per cycle, makes the polynomial writable, and adds a programmable seed register. Adds error signalling for illegal accesses. Sits on the peripheral APB3 bus behind the system interconnect.

Parameters:
CRC_W, 32, CRC register and polynomial width; legal range 8..32.
BITS_PER_CYCLE, 1, data bits consumed per clock; must be 1, 2, 4 or 8.
ADDR_W, 5, PADDR width; only byte offsets 0x00..0x10 are mapped.

Ports:
PCLK  in  1  APB clock; the only clock of the block.
PRESETn  in  1  asynchronous, active-low reset.
PSEL  in  1  APB select.
PENABLE  in  1  APB access phase.
PWRITE  in  1  1 = write.
PADDR  in  ADDR_W  byte address; bits [1:0] are ignored.
PWDATA  in  32  write data.
PRDATA  out  32  read data.
PREADY  out  1  tied to 1; every access completes with zero wait states.
PSLVERR  out  1  error response, valid in the access phase.

Behaviour:
- Interface: one clock (PCLK). Reset PRESETn is asynchronous, active-low.
- Reset state:
  - POLY=0, DATA_IN=0, INIT_VAL=0, crc=0.
  - busy=0, finish_status=0.
  - PRDATA=0, PSLVERR=0.
- Register map (byte offsets):
  - 0x00 POLY: RW, bits [CRC_W-1:0]; upper bits read 0.
  - 0x04 DATA_IN: RW, 32 bits.
  - 0x08 DATA_OUT: RO; returns crc zero-extended to 32 bits.
  - 0x0C CONTROL:
    - bit0 start: W, self-clearing, reads 0.
    - bit8 init: W, self-clearing, reads 0.
    - bit16 finish_status: W1C.
    - bit24 busy: RO.
    - All other bits RO 0.
  - 0x10 INIT_VAL: RW, bits [CRC_W-1:0].
- APB timing:
  - A write takes effect on the PCLK edge where PSEL and PENABLE are both 1.
  - PRDATA is driven combinationally during the access phase from current register state.
  - PRDATA is 0 when PSEL is 0.
- PSLVERR=1 in the access phase when either of these holds:
  - The address is unmapped (0x14 and above); the access has no effect.
  - A write hits POLY, DATA_IN or INIT_VAL, or sets start or init, while busy=1. The whole write is discarded, including a W1C of finish_status in the same word.
  - Reads never error, except to unmapped addresses.
- FSM, IDLE -> RUN -> IDLE:
  - IDLE: on a write of start=1, latch DATA_IN into the shift register, load the bit counter with 32/BITS_PER_CYCLE, set busy=1, go to RUN.
  - RUN: each cycle, consume BITS_PER_CYCLE bits, MSB first. For each bit b, applied sequentially within the cycle:
    - fb = crc[CRC_W-1] ^ b
    - crc = (crc << 1) ^ (fb ? POLY : 0), truncated to CRC_W bits.
  - RUN exit: when the counter reaches its last step, go to IDLE on the next edge, clear busy, set finish_status.
  - Latency from the start write edge to busy=0: exactly 32/BITS_PER_CYCLE cycles.
- init=1 in IDLE: crc <= INIT_VAL on that edge.
- init=1 and start=1 in the same write: the seed is applied first, so the first step operates on INIT_VAL.
- A write to INIT_VAL in the same cycle as init=1 seeds crc with the old INIT_VAL.
- Without init, crc accumulates across successive starts (chained words).
- finish_status set and W1C on the same edge: set wins.
- PRESETn asserted mid-RUN: the operation is aborted immediately and all state returns to reset values. No finish_status is produced.

Optional Feature:
Macro CRC_IRQ_EN.
- Defined:
  - Output port irq (1 bit) is added.
  - CONTROL bit 31 irq_en becomes RW, reset 0.
  - irq = finish_status & irq_en, level-sensitive, reset 0.
- Undefined:
  - No irq port.
  - Bit 31 reads 0 and writes to it are ignored.

Decomposition:
- Package apb3_crc_pkg:
  - Register offset localparams.
  - Control bit-position constants.
  - Packed typedefs: poly_reg_t, init_val_reg_t, data_in_reg_t, data_out_reg_t, control_reg_t (reserved fields explicit).
  - regmap_t.
- Sub-module crc_engine: owns the FSM, bit counter, shift register and crc register.
  - Inputs: start, init, poly, seed, data.
  - Outputs: crc, busy, done pulse.
- The top level holds the APB decode, register file and PSLVERR logic.

Test Plan:
- Reset: all registers read 0; busy=0; PSLVERR=0 on all mapped reads.
- CRC_W=32, POLY=0x04C11DB7, init with INIT_VAL=0, DATA_IN=0x00000001, start:
  - busy=1 for exactly 32 cycles.
  - DATA_OUT=0x04C11DB7, finish_status=1.
  - W1C of bit16 clears finish_status.
- CRC_W=8, BITS_PER_CYCLE=4, POLY=0x07, init with seed 0, DATA_IN=0x00000001, start:
  - busy for 8 cycles.
  - DATA_OUT=0x00000007.
  - Reading POLY with 0xFFFFFFFF written returns 0x000000FF.
- While busy, write DATA_IN=0x1234 and write start:
  - PSLVERR=1 on both.
  - DATA_IN keeps its old value; result unchanged.
  - Read of 0x14 gives PSLVERR=1.
- Chained words: init (seed 0), start with DATA_IN=0x00000001, then start with DATA_IN=0 without init. DATA_OUT equals the CRC of the 64-bit message 0x00000001_00000000 per the reference model.
- Assert PRESETn mid-RUN (cycle 10): busy=0, DATA_OUT=0, finish_status=0. With CRC_IRQ_EN defined, irq rises when finish_status=1 and irq_en=1, and falls on W1C.

Source files
------------

// File: rtl/apb3_crc_pkg.sv
// Register map, control-word layout and engine state encoding shared by the
// APB3 CRC engine top level and its crc_engine core.
package apb3_crc_pkg;

    localparam logic [31:0] OFF_POLY     = 32'h00;
    localparam logic [31:0] OFF_DATA_IN  = 32'h04;
    localparam logic [31:0] OFF_DATA_OUT = 32'h08;
    localparam logic [31:0] OFF_CONTROL  = 32'h0C;
    localparam logic [31:0] OFF_INIT_VAL = 32'h10;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_INIT_BIT   = 8;
    localparam int CTRL_FINISH_BIT = 16;
    localparam int CTRL_BUSY_BIT   = 24;
    localparam int CTRL_IRQ_EN_BIT = 31;

    // Full 32-bit bus views; CRC_W-wide fields occupy the low bits.
    typedef logic [31:0] poly_reg_t;
    typedef logic [31:0] init_val_reg_t;
    typedef logic [31:0] data_in_reg_t;
    typedef logic [31:0] data_out_reg_t;

    typedef struct packed {
        logic       irq_en;
        logic [5:0] rsvd_30_25;
        logic       busy;
        logic [6:0] rsvd_23_17;
        logic       finish_status;
        logic [6:0] rsvd_15_9;
        logic       init;
        logic [6:0] rsvd_7_1;
        logic       start;
    } control_reg_t;

    typedef enum logic [2:0] {
        RM_POLY,
        RM_DATA_IN,
        RM_DATA_OUT,
        RM_CONTROL,
        RM_INIT_VAL,
        RM_UNMAPPED
    } regmap_t;

    typedef enum logic {
        ENG_IDLE,
        ENG_RUN
    } eng_state_t;

    // Byte-lane bits [1:0] are ignored; everything from 0x14 up is unmapped.
    function automatic regmap_t decode_addr(input logic [31:0] addr);
        regmap_t r;
        case ({addr[31:2], 2'b00})
            OFF_POLY:     r = RM_POLY;
            OFF_DATA_IN:  r = RM_DATA_IN;
            OFF_DATA_OUT: r = RM_DATA_OUT;
            OFF_CONTROL:  r = RM_CONTROL;
            OFF_INIT_VAL: r = RM_INIT_VAL;
            default:      r = RM_UNMAPPED;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/crc_engine.sv
// Bit-serial/parallel CRC core: shifts a 32-bit word MSB first through an
// LFSR, BITS_PER_CYCLE bits per clock, with seed load and chaining.
module crc_engine
    import apb3_crc_pkg::*;
#(
    parameter int CRC_W          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             init_i,
    input  logic [CRC_W-1:0] poly_i,
    input  logic [CRC_W-1:0] seed_i,
    input  logic [31:0]      data_i,
    output logic [CRC_W-1:0] crc_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int STEPS = 32 / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);

    eng_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      shreg_q, shreg_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W-1:0] crc_step;

    // NOTE: blocking assignments are intended here: each bit of the cycle
    // must see the crc produced by the previous bit within the same cycle.
    always_comb begin
        crc_step = crc_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin : g_bit
            logic fb;
            fb       = crc_step[CRC_W-1] ^ shreg_q[31-i];
            crc_step = {crc_step[CRC_W-2:0], 1'b0} ^ (fb ? poly_i : '0);
        end
    end

    // NOTE: every next-state signal gets its hold value first so no path
    // through the case statement can leave one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        crc_d   = crc_q;
        case (state_q)
            ENG_IDLE: begin
                if (init_i) begin
                    crc_d = seed_i;
                end
                if (start_i) begin
                    shreg_d = data_i;
                    cnt_d   = CNT_W'(STEPS);
                    state_d = ENG_RUN;
                end
            end
            ENG_RUN: begin
                crc_d   = crc_step;
                shreg_d = shreg_q << BITS_PER_CYCLE;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ENG_IDLE;
                end
            end
            default: state_d = ENG_IDLE;
        endcase
    end

    // NOTE: the shift register is datapath, but it is still reset so that
    // an abort mid-operation leaves no stale word behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENG_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            crc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            crc_q   <= crc_d;
        end
    end

    assign crc_o  = crc_q;
    assign busy_o = (state_q == ENG_RUN);
    assign done_o = (state_q == ENG_RUN) && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/apb3_crc_engine.sv
// APB3 slave around crc_engine: address decode, register file, PSLVERR.
// Optional interrupt output enabled by defining CRC_IRQ_EN.
module apb3_crc_engine
    import apb3_crc_pkg::*;
#(
    parameter int CRC_W          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int ADDR_W         = 5
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
`ifdef CRC_IRQ_EN
    ,
    output logic              irq
`endif
);

    regmap_t          sel;
    logic             access;
    logic             wr_locked;
    logic             err;
    logic             wr_ok;
    logic             ctrl_wr;
    logic             eng_start;
    logic             eng_init;
    logic             eng_busy;
    logic             eng_done;
    logic [CRC_W-1:0] eng_crc;

    logic [CRC_W-1:0] poly_q;
    logic [CRC_W-1:0] init_val_q;
    data_in_reg_t     data_in_q;
    logic             fs_q, fs_d;
    control_reg_t     ctrl_rd;
    data_out_reg_t    data_out;

    assign access = PSEL & PENABLE;
    assign sel    = decode_addr(32'(PADDR));

    // Configuration writes and start/init are refused while the engine runs.
    always_comb begin
        wr_locked = 1'b0;
        if (eng_busy) begin
            case (sel)
                RM_POLY, RM_DATA_IN, RM_INIT_VAL: wr_locked = 1'b1;
                RM_CONTROL: wr_locked = PWDATA[CTRL_START_BIT] | PWDATA[CTRL_INIT_BIT];
                default:    wr_locked = 1'b0;
            endcase
        end
    end

    assign err       = (sel == RM_UNMAPPED) | (PWRITE & wr_locked);
    assign PSLVERR   = access & err;
    assign PREADY    = 1'b1;
    assign wr_ok     = access & PWRITE & ~err;
    assign ctrl_wr   = wr_ok & (sel == RM_CONTROL);
    assign eng_start = ctrl_wr & PWDATA[CTRL_START_BIT];
    assign eng_init  = ctrl_wr & PWDATA[CTRL_INIT_BIT];

    // Completion is applied after the W1C so a same-edge set wins.
    always_comb begin
        fs_d = fs_q;
        if (ctrl_wr && PWDATA[CTRL_FINISH_BIT]) begin
            fs_d = 1'b0;
        end
        if (eng_done) begin
            fs_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            poly_q     <= '0;
            init_val_q <= '0;
            data_in_q  <= '0;
            fs_q       <= 1'b0;
        end else begin
            if (wr_ok && sel == RM_POLY)     poly_q     <= PWDATA[CRC_W-1:0];
            if (wr_ok && sel == RM_INIT_VAL) init_val_q <= PWDATA[CRC_W-1:0];
            if (wr_ok && sel == RM_DATA_IN)  data_in_q  <= PWDATA;
            fs_q <= fs_d;
        end
    end

`ifdef CRC_IRQ_EN
    logic irq_en_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq_en_q <= 1'b0;
        end else if (ctrl_wr) begin
            irq_en_q <= PWDATA[CTRL_IRQ_EN_BIT];
        end
    end

    assign irq = fs_q & irq_en_q;
`endif

    always_comb begin
        ctrl_rd               = '0;
        ctrl_rd.busy          = eng_busy;
        ctrl_rd.finish_status = fs_q;
`ifdef CRC_IRQ_EN
        ctrl_rd.irq_en        = irq_en_q;
`endif
    end

    assign data_out = 32'(eng_crc);

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            case (sel)
                RM_POLY:     PRDATA = 32'(poly_q);
                RM_DATA_IN:  PRDATA = data_in_q;
                RM_DATA_OUT: PRDATA = data_out;
                RM_CONTROL:  PRDATA = ctrl_rd;
                RM_INIT_VAL: PRDATA = 32'(init_val_q);
                default:     PRDATA = '0;
            endcase
        end
    end

    crc_engine #(
        .CRC_W          (CRC_W),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_engine (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .start_i (eng_start),
        .init_i  (eng_init),
        .poly_i  (poly_q),
        .seed_i  (init_val_q),
        .data_i  (data_in_q),
        .crc_o   (eng_crc),
        .busy_o  (eng_busy),
        .done_o  (eng_done)
    );

endmodule
